// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, coordinate width and FSM state type
// for the VGA timing generator and its sibling PLL-locked consumers.
package vga_pkg;

  // Coordinate / counter width for x, y, hcnt and vcnt.
  localparam int XY_W = 10;

  // Horizontal timing in pixels.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Asserted level of hsync/vsync (0 = active-low).
  localparam logic VGA_SYNC_POL = 1'b0;

  // Consecutive synchronised-locked cycles needed before running.
  localparam int VGA_SETTLE_CYCLES = 16;

  // Lock-qualification / run state.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } vga_state_e;

  // Total period of one axis given its four regions.
  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: qualifies PLL lock, then produces hsync/vsync,
// data-enable, pixel coordinates and line/frame strobes. All outputs are
// registered once and describe the same counter position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE      = VGA_H_ACTIVE,
  parameter int   H_FP          = VGA_H_FP,
  parameter int   H_SYNC        = VGA_H_SYNC,
  parameter int   H_BP          = VGA_H_BP,
  parameter int   V_ACTIVE      = VGA_V_ACTIVE,
  parameter int   V_FP          = VGA_V_FP,
  parameter int   V_SYNC        = VGA_V_SYNC,
  parameter int   V_BP          = VGA_V_BP,
  parameter logic SYNC_POL      = VGA_SYNC_POL,
  parameter int   SETTLE_CYCLES = VGA_SETTLE_CYCLES
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            locked,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y,
  output logic            line_start,
  output logic            frame_start,
  output logic            running
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Region boundaries as counter-width constants (end values are exclusive).
  localparam logic [XY_W-1:0] H_ACT_END  = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] H_SYNC_BEG = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] H_SYNC_END = XY_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XY_W-1:0] H_LAST     = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] V_ACT_END  = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0] V_SYNC_BEG = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] V_SYNC_END = XY_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XY_W-1:0] V_LAST     = XY_W'(V_TOTAL - 1);

  // Settle counter is one bit wider than strictly needed so the terminal
  // count always fits, whatever SETTLE_CYCLES is set to.
  localparam int                 SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic                lock_s;
  vga_state_e          state_q;
  vga_state_e          state_d;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [XY_W-1:0]     hcnt;
  logic [XY_W-1:0]     vcnt;

  logic                in_run;
  logic                h_act;
  logic                h_syn;
  logic                v_act;
  logic                v_syn;
  logic                de_c;

  logic                hsync_p1;
  logic                vsync_p1;
  logic                de_p1;
  logic [XY_W-1:0]     x_p1;
  logic [XY_W-1:0]     y_p1;
  logic                line_start_p1;
  logic                frame_start_p1;
  logic                running_p1;

  // locked comes straight from the PLL and is asynchronous to refclk.
  sync2 #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // FSM state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: any loss of synchronised lock drops back to WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  // Settle counter: counts synchronised-locked cycles only while in SETTLE.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if ((state_q == SETTLE) && lock_s) begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end else begin
      settle_cnt <= '0;
    end
  end

  // Raster counters: advance only while running with lock held, otherwise
  // parked at 0 so RUN is always entered at the top-left pixel.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if ((state_q == RUN) && lock_s) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + XY_W'(1);
        end
      end else begin
        hcnt <= hcnt + XY_W'(1);
      end
    end else begin
      hcnt <= '0;
      vcnt <= '0;
    end
  end

  // Region decode of the current counter position.
  assign in_run = (state_q == RUN);
  assign h_act  = (hcnt < H_ACT_END);
  assign h_syn  = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
  assign v_act  = (vcnt < V_ACT_END);
  assign v_syn  = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
  assign de_c   = h_act && v_act;

  // ---- stage boundary: decoded timing -> registered outputs (_p1) ----
  // Outputs are forced idle whenever the FSM is not in RUN.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      hsync_p1       <= ~SYNC_POL;
      vsync_p1       <= ~SYNC_POL;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      running_p1     <= 1'b0;
    end else if (in_run) begin
      hsync_p1       <= h_syn ? SYNC_POL : ~SYNC_POL;
      vsync_p1       <= v_syn ? SYNC_POL : ~SYNC_POL;
      de_p1          <= de_c;
      x_p1           <= de_c ? hcnt : '0;
      y_p1           <= de_c ? vcnt : '0;
      line_start_p1  <= (hcnt == '0) && v_act;
      frame_start_p1 <= (hcnt == '0) && (vcnt == '0);
      running_p1     <= 1'b1;
    end else begin
      hsync_p1       <= ~SYNC_POL;
      vsync_p1       <= ~SYNC_POL;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      running_p1     <= 1'b0;
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign de          = de_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign line_start  = line_start_p1;
  assign frame_start = frame_start_p1;
  assign running     = running_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size 640x480 instance and one shrunken
// instance (short frame, active-high syncs) share clock, reset and locked.
// Expected outputs come from a raster-position model driven by the history
// of locked samples.
module tb_vga_timing_gen;

  logic       refclk = 1'b0;
  logic       rst    = 1'b0;
  logic       locked = 1'b0;
  logic       clk_en = 1'b1;

  logic       d_hs, d_vs, d_de, d_ls, d_fs, d_run;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs, s_run;
  logic [9:0] s_x, s_y;

  int n_cmp = 0;
  int n_bad = 0;

  // Streak of consecutive high locked samples, one entry per clock edge since reset.
  int hist[$];

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       run;
  } exp_t;

  always begin
    #20;
    if (clk_en) refclk = ~refclk;
  end

  vga_timing_gen dut_d (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .de          (d_de),
    .x           (d_x),
    .y           (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .running     (d_run)
  );

  vga_timing_gen #(
    .H_ACTIVE      (16),
    .H_FP          (4),
    .H_SYNC        (6),
    .H_BP          (6),
    .V_ACTIVE      (12),
    .V_FP          (2),
    .V_SYNC        (2),
    .V_BP          (3),
    .SYNC_POL      (1'b1),
    .SETTLE_CYCLES (16)
  ) dut_s (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .de          (s_de),
    .x           (s_x),
    .y           (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .running     (s_run)
  );

  // Outputs after edge n describe the raster one edge earlier, whose lock
  // view lags locked by the two synchroniser flops: so the relevant streak
  // is the one ending three edges back.
  function automatic int out_streak();
    int i;
    i = hist.size() - 4;
    return (i < 0) ? 0 : hist[i];
  endfunction

  // Running needs settle+1 consecutive synchronised-high samples; after that
  // each further cycle is one raster position.
  function automatic exp_t model(input int l, input int settle,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input logic pol);
    exp_t e;
    int   ht, vt, pos, h, v;
    e     = '0;
    e.hs  = ~pol;
    e.vs  = ~pol;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    if (l >= settle + 1) begin
      pos   = l - settle - 1;
      h     = pos % ht;
      v     = (pos / ht) % vt;
      e.run = 1'b1;
      if (h >= ha + hf && h < ha + hf + hsw) e.hs = pol;
      if (v >= va + vf && v < va + vf + vsw) e.vs = pol;
      e.de  = (h < ha) && (v < va);
      if (e.de) begin
        e.x = 10'(h);
        e.y = 10'(v);
      end
      e.ls  = (h == 0) && (v < va);
      e.fs  = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    exp_t ed, es;
    int   l;
    l  = out_streak();
    ed = model(l, 16, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    es = model(l, 16, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1);
    chk("d.hsync",       {9'b0, d_hs},  {9'b0, ed.hs});
    chk("d.vsync",       {9'b0, d_vs},  {9'b0, ed.vs});
    chk("d.de",          {9'b0, d_de},  {9'b0, ed.de});
    chk("d.x",           d_x,           ed.x);
    chk("d.y",           d_y,           ed.y);
    chk("d.line_start",  {9'b0, d_ls},  {9'b0, ed.ls});
    chk("d.frame_start", {9'b0, d_fs},  {9'b0, ed.fs});
    chk("d.running",     {9'b0, d_run}, {9'b0, ed.run});
    chk("s.hsync",       {9'b0, s_hs},  {9'b0, es.hs});
    chk("s.vsync",       {9'b0, s_vs},  {9'b0, es.vs});
    chk("s.de",          {9'b0, s_de},  {9'b0, es.de});
    chk("s.x",           s_x,           es.x);
    chk("s.y",           s_y,           es.y);
    chk("s.line_start",  {9'b0, s_ls},  {9'b0, es.ls});
    chk("s.frame_start", {9'b0, s_fs},  {9'b0, es.fs});
    chk("s.running",     {9'b0, s_run}, {9'b0, es.run});
  endtask

  // Drive locked, advance one clock, record the sample and check outputs.
  task automatic step(input logic lk);
    int prev;
    locked = lk;
    @(posedge refclk);
    #1;
    if (!rst) begin
      prev = (hist.size() == 0) ? 0 : hist[hist.size() - 1];
      hist.push_back(lk ? prev + 1 : 0);
    end
    check_all();
  endtask

  task automatic steps(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk);
  endtask

  initial begin
    // Reset held for 5 cycles, idle outputs throughout.
    #2;
    rst = 1'b1;
    hist.delete();
    #1;
    check_all();
    steps(1'b0, 5);
    rst = 1'b0;

    // locked rises at cycle 10; glitch low for 3 cycles after 10 high.
    steps(1'b0, 4);
    steps(1'b1, 10);
    steps(1'b0, 3);

    // Clean lock: RUN, then two short frames and 1.6 full-size lines.
    steps(1'b1, 1300);

    // Lock loss mid-frame, then recovery from frame_start.
    steps(1'b0, 5);
    steps(1'b1, 700);

    // Random lock dropouts.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0);
    end
    steps(1'b1, 100);

    // Asynchronous reset with the clock stopped.
    clk_en = 1'b0;
    #50;
    rst = 1'b1;
    hist.delete();
    #5;
    check_all();
    #30;
    rst = 1'b0;
    #5;
    check_all();
    clk_en = 1'b1;

    // Normal lock sequence after reset.
    steps(1'b1, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
